// File: rtl/note_pkg.sv
// Shared definitions for the note front end.
// NUM_NOTES  : number of note keys / tone generators in the instrument.
// note_idx_t : index of one note key.
// note_e     : note names in tone-generator instance order (bit i of the
//              gate vector drives the generator for note_e'(i)).
package note_pkg;

  localparam int NUM_NOTES = 7;

  typedef logic [2:0] note_idx_t;

  typedef enum logic [2:0] {
    NOTE_C = 3'd0,
    NOTE_D = 3'd1,
    NOTE_E = 3'd2,
    NOTE_F = 3'd3,
    NOTE_G = 3'd4,
    NOTE_A = 3'd5,
    NOTE_B = 3'd6
  } note_e;

endpackage

// File: rtl/key_debouncer.sv
// Single-key conditioner: 2-FF synchroniser followed by a persistence
// counter. A synchronised level must differ from the accepted level for
// DEBOUNCE_CYCLES consecutive cycles before it becomes the new stable level.
// Ports:
//   clk     : system clock
//   rst     : synchronous reset, active-high
//   key_raw : asynchronous button level, 1 = pressed
//   stable  : debounced (accepted) key level
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_r;
  logic             s2_r;
  logic             stable_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronise the raw level, then count how long it disagrees with the accepted level.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r     <= 1'b0;
      s2_r     <= 1'b0;
      stable_r <= 1'b0;
      cnt_r    <= '0;
    end else begin
      s1_r <= key_raw;
      s2_r <= s1_r;
      if (s2_r == stable_r) begin
        // Any return to the accepted level restarts the persistence window.
        cnt_r <= '0;
      end else if (cnt_r == CNT_MAX) begin
        stable_r <= s2_r;
        cnt_r    <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign stable = stable_r;

endmodule

// File: rtl/key_debounce_select.sv
// Monophonic key front end for the per-note tone generators.
// Each key is synchronised and debounced; the most recently pressed key
// (lowest index on a tie) is selected and gated through a registered
// one-hot vector so only one tone generator is enabled at a time.
// Ports:
//   clk         : system clock
//   rst         : synchronous reset, active-high
//   keys_raw    : asynchronous button levels, 1 = pressed
//   key_state   : debounced key levels
//   note_en     : one-hot gate to tone generators, zero when nothing selected
//   note_idx    : index of the selected key, held while note_valid = 0
//   note_valid  : a note is selected
//   press_pulse : one-cycle strobe on any accepted press event
module key_debounce_select
  import note_pkg::*;
#(
  parameter int  NUM_KEYS        = NUM_NOTES,
  parameter int  DEBOUNCE_CYCLES = 1000000,
  localparam int IDX_W           = $clog2(NUM_KEYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_raw,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] note_en,
  output logic [IDX_W-1:0]    note_idx,
  output logic                note_valid,
  output logic                press_pulse
);

  logic [NUM_KEYS-1:0] key_state_s;
  logic [NUM_KEYS-1:0] prev_r;
  logic [NUM_KEYS-1:0] press_s;
  logic [NUM_KEYS-1:0] rel_s;
  logic [NUM_KEYS-1:0] note_en_r;
  logic [NUM_KEYS-1:0] note_en_nxt_s;
  logic [IDX_W-1:0]    note_idx_r;
  logic [IDX_W-1:0]    note_idx_nxt_s;
  logic                note_valid_r;
  logic                note_valid_nxt_s;
  logic                press_pulse_r;
  logic                press_pulse_nxt_s;

  // Index of the lowest set bit; zero when nothing is set.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = IDX_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // One-hot decode of a key index.
  function automatic logic [NUM_KEYS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_KEYS-1:0] oh;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (IDX_W'(i) == idx) begin
        oh[i] = 1'b1;
      end else begin
        oh[i] = 1'b0;
      end
    end
    return oh;
  endfunction

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_deb
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .key_raw(keys_raw[g]),
      .stable (key_state_s[g])
    );
  end

  assign press_s = key_state_s & ~prev_r;
  assign rel_s   = ~key_state_s & prev_r;

  // Next selection: presses win, then fall back to the lowest held key when the selected one is released.
  always_comb begin
    note_idx_nxt_s    = note_idx_r;
    note_valid_nxt_s  = note_valid_r;
    press_pulse_nxt_s = 1'b0;
    if (|press_s) begin
      note_idx_nxt_s    = lowest_idx(press_s);
      note_valid_nxt_s  = 1'b1;
      press_pulse_nxt_s = 1'b1;
    end else if (note_valid_r && rel_s[note_idx_r]) begin
      if (|key_state_s) begin
        note_idx_nxt_s   = lowest_idx(key_state_s);
        note_valid_nxt_s = 1'b1;
      end else begin
        // note_idx deliberately keeps the last selected key.
        note_valid_nxt_s = 1'b0;
      end
    end else begin
      note_idx_nxt_s   = note_idx_r;
      note_valid_nxt_s = note_valid_r;
    end
    if (note_valid_nxt_s) begin
      note_en_nxt_s = idx_to_onehot(note_idx_nxt_s);
    end else begin
      note_en_nxt_s = '0;
    end
  end

  // Register the previous key levels and the selection outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_r        <= '0;
      note_en_r     <= '0;
      note_idx_r    <= '0;
      note_valid_r  <= 1'b0;
      press_pulse_r <= 1'b0;
    end else begin
      prev_r        <= key_state_s;
      note_en_r     <= note_en_nxt_s;
      note_idx_r    <= note_idx_nxt_s;
      note_valid_r  <= note_valid_nxt_s;
      press_pulse_r <= press_pulse_nxt_s;
    end
  end

  assign key_state   = key_state_s;
  assign note_en     = note_en_r;
  assign note_idx    = note_idx_r;
  assign note_valid  = note_valid_r;
  assign press_pulse = press_pulse_r;

endmodule

// File: tb/tb_key_debounce_select.sv
// Scoreboard bench for key_debounce_select with DEBOUNCE_CYCLES=4, 7 keys.
// Stimulus pushes the expected output events (with the edge number at which
// each must appear); the monitor pops one entry whenever any output changes
// (or a snapshot is requested) and compares every field including timing.
module tb_key_debounce_select;

  localparam int NK = 7;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] keys_raw;
  logic [NK-1:0] key_state;
  logic [NK-1:0] note_en;
  logic [2:0]    note_idx;
  logic          note_valid;
  logic          press_pulse;

  key_debounce_select #(
    .NUM_KEYS(NK),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .keys_raw   (keys_raw),
    .key_state  (key_state),
    .note_en    (note_en),
    .note_idx   (note_idx),
    .note_valid (note_valid),
    .press_pulse(press_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [NK-1:0] ks;
    logic [NK-1:0] en;
    logic [2:0]    idx;
    logic          v;
    logic          p;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   sample_req = 1'b0;

  logic [NK-1:0] p_ks = '0;
  logic [NK-1:0] p_en = '0;
  logic [2:0]    p_idx = '0;
  logic          p_v = 1'b0;
  logic          p_p = 1'b0;

  // Edge counter: after edge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_ev(input int c, input logic [NK-1:0] ks, input logic [NK-1:0] en,
                           input logic [2:0] idx, input logic v, input logic p);
    exp_t e;
    e.cyc = c; e.ks = ks; e.en = en; e.idx = idx; e.v = v; e.p = p;
    q.push_back(e);
  endtask

  // Drive keys just after an edge; returns the edge count at drive time.
  task automatic drive_keys(input logic [NK-1:0] k, output int t);
    keys_raw = k;
    t = cyc;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Monitor: compare on every output change or snapshot request.
  always @(negedge clk) begin
    exp_t e;
    bit   changed;
    changed = (key_state !== p_ks) || (note_en !== p_en) || (note_idx !== p_idx) ||
              (note_valid !== p_v) || (press_pulse !== p_p);
    if (mon_en && (changed || sample_req)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got ks=%b en=%b idx=%0d v=%b p=%b, required no change",
                 cyc, key_state, note_en, note_idx, note_valid, press_pulse);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || key_state !== e.ks || note_en !== e.en || note_idx !== e.idx ||
            note_valid !== e.v || press_pulse !== e.p) begin
          errors++;
          $display("FAIL event got cyc=%0d ks=%b en=%b idx=%0d v=%b p=%b, required cyc=%0d ks=%b en=%b idx=%0d v=%b p=%b",
                   cyc, key_state, note_en, note_idx, note_valid, press_pulse,
                   e.cyc, e.ks, e.en, e.idx, e.v, e.p);
        end
      end
      sample_req = 1'b0;
    end
    p_ks = key_state; p_en = note_en; p_idx = note_idx; p_v = note_valid; p_p = press_pulse;
  end

  initial begin
    int t;
    rst = 1'b1;
    keys_raw = '0;
    // 1: reset held three edges, outputs zero and stay zero.
    wait_cycles(3);
    rst = 1'b0;
    mon_en = 1'b1;
    expect_ev(cyc, 7'b0000000, 7'b0000000, 3'd0, 1'b0, 1'b0);
    sample_req = 1'b1;
    wait_cycles(20);
    expect_ev(cyc, 7'b0000000, 7'b0000000, 3'd0, 1'b0, 1'b0);
    sample_req = 1'b1;
    wait_cycles(2);

    // 2: key 4 pressed and held, then released.
    drive_keys(7'b0010000, t);
    expect_ev(t + 6, 7'b0010000, 7'b0000000, 3'd0, 1'b0, 1'b0);
    expect_ev(t + 7, 7'b0010000, 7'b0010000, 3'd4, 1'b1, 1'b1);
    expect_ev(t + 8, 7'b0010000, 7'b0010000, 3'd4, 1'b1, 1'b0);
    wait_cycles(10);
    drive_keys(7'b0000000, t);
    expect_ev(t + 6, 7'b0000000, 7'b0010000, 3'd4, 1'b1, 1'b0);
    expect_ev(t + 7, 7'b0000000, 7'b0000000, 3'd4, 1'b0, 1'b0);
    wait_cycles(10);

    // 3: 3-cycle glitch on key 2 is rejected; a 4-cycle pulse is accepted.
    drive_keys(7'b0000100, t);
    wait_cycles(3);
    drive_keys(7'b0000000, t);
    wait_cycles(12);
    drive_keys(7'b0000100, t);
    expect_ev(t + 6, 7'b0000100, 7'b0000000, 3'd4, 1'b0, 1'b0);
    expect_ev(t + 7, 7'b0000100, 7'b0000100, 3'd2, 1'b1, 1'b1);
    expect_ev(t + 8, 7'b0000100, 7'b0000100, 3'd2, 1'b1, 1'b0);
    expect_ev(t + 10, 7'b0000000, 7'b0000100, 3'd2, 1'b1, 1'b0);
    expect_ev(t + 11, 7'b0000000, 7'b0000000, 3'd2, 1'b0, 1'b0);
    wait_cycles(4);
    drive_keys(7'b0000000, t);
    wait_cycles(12);

    // 4: key 1 held, key 5 overrides, fall back to 1, then nothing held.
    drive_keys(7'b0000010, t);
    expect_ev(t + 6, 7'b0000010, 7'b0000000, 3'd2, 1'b0, 1'b0);
    expect_ev(t + 7, 7'b0000010, 7'b0000010, 3'd1, 1'b1, 1'b1);
    expect_ev(t + 8, 7'b0000010, 7'b0000010, 3'd1, 1'b1, 1'b0);
    wait_cycles(10);
    drive_keys(7'b0100010, t);
    expect_ev(t + 6, 7'b0100010, 7'b0000010, 3'd1, 1'b1, 1'b0);
    expect_ev(t + 7, 7'b0100010, 7'b0100000, 3'd5, 1'b1, 1'b1);
    expect_ev(t + 8, 7'b0100010, 7'b0100000, 3'd5, 1'b1, 1'b0);
    wait_cycles(10);
    drive_keys(7'b0000010, t);
    expect_ev(t + 6, 7'b0000010, 7'b0100000, 3'd5, 1'b1, 1'b0);
    expect_ev(t + 7, 7'b0000010, 7'b0000010, 3'd1, 1'b1, 1'b0);
    wait_cycles(10);
    drive_keys(7'b0000000, t);
    expect_ev(t + 6, 7'b0000000, 7'b0000010, 3'd1, 1'b1, 1'b0);
    expect_ev(t + 7, 7'b0000000, 7'b0000000, 3'd1, 1'b0, 1'b0);
    wait_cycles(10);

    // 5: keys 3 and 6 together, lowest wins; release 3 falls back to 6.
    drive_keys(7'b1001000, t);
    expect_ev(t + 6, 7'b1001000, 7'b0000000, 3'd1, 1'b0, 1'b0);
    expect_ev(t + 7, 7'b1001000, 7'b0001000, 3'd3, 1'b1, 1'b1);
    expect_ev(t + 8, 7'b1001000, 7'b0001000, 3'd3, 1'b1, 1'b0);
    wait_cycles(10);
    drive_keys(7'b1000000, t);
    expect_ev(t + 6, 7'b1000000, 7'b0001000, 3'd3, 1'b1, 1'b0);
    expect_ev(t + 7, 7'b1000000, 7'b1000000, 3'd6, 1'b1, 1'b0);
    wait_cycles(10);
    drive_keys(7'b0000000, t);
    expect_ev(t + 6, 7'b0000000, 7'b1000000, 3'd6, 1'b1, 1'b0);
    expect_ev(t + 7, 7'b0000000, 7'b0000000, 3'd6, 1'b0, 1'b0);
    wait_cycles(10);

    // 6: key 0 selected, one-cycle reset with key still held, reselection.
    drive_keys(7'b0000001, t);
    expect_ev(t + 6, 7'b0000001, 7'b0000000, 3'd6, 1'b0, 1'b0);
    expect_ev(t + 7, 7'b0000001, 7'b0000001, 3'd0, 1'b1, 1'b1);
    expect_ev(t + 8, 7'b0000001, 7'b0000001, 3'd0, 1'b1, 1'b0);
    wait_cycles(10);
    rst = 1'b1;
    expect_ev(cyc + 1, 7'b0000000, 7'b0000000, 3'd0, 1'b0, 1'b0);
    wait_cycles(1);
    rst = 1'b0;
    t = cyc;
    expect_ev(t + 6, 7'b0000001, 7'b0000000, 3'd0, 1'b0, 1'b0);
    expect_ev(t + 7, 7'b0000001, 7'b0000001, 3'd0, 1'b1, 1'b1);
    expect_ev(t + 8, 7'b0000001, 7'b0000001, 3'd0, 1'b1, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
    wait_cycles(3);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_event required cyc=%0d ks=%b en=%b idx=%0d v=%b p=%b, got no output change",
               e.cyc, e.ks, e.en, e.idx, e.v, e.p);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
